spi_exe_master: RTL and testbench
=================================

SPI_EXE_MASTER -- requirements
Module: spi_exe_master

Interface
REQ-001 Parameter DIV, default 2, system clocks per SCLK half-period (legal range 1..255).
REQ-002 Parameter RESP_BITS, default 28, response bits clocked in per frame.
REQ-003 Parameter GAP_SCLK, default 1, SCLK periods between command and response phases.
REQ-004 i_clk_p  input  1  system clock; single clock domain; all logic on rising edge.
REQ-005 i_rst_n  input  1  reset; synchronous, active-low.
REQ-006 i_start  input  1  request a transaction; sampled only in IDLE.
REQ-007 i_argA  input  8  operand A.
REQ-008 i_argB  input  8  operand B.
REQ-009 i_oper  input  4  operation code.
REQ-010 i_miso  input  1  serial data from execution slave.
REQ-011 o_sclk  output  1  SPI clock; idle low.
REQ-012 o_cs_n  output  1  chip select; active-low.
REQ-013 o_mosi  output  1  serial data to slave, MSB first.
REQ-014 o_result  output  8  result byte of last completed frame.
REQ-015 o_flags  output  4  flags of last frame: [0]=OF, [1]=SF, [2]=BF, [3]=VF.
REQ-016 o_valid  output  1  one-cycle pulse when o_result/o_flags update.
REQ-017 o_busy  output  1  high from start acceptance until the cycle o_valid pulses, inclusive.

Function
REQ-018 States SHALL be IDLE, SETUP, TX, GAP, RX, DONE; encoding is free.
REQ-019 IDLE: on i_start=1 SHALL capture {i_argA, i_argB, i_oper, 4'b0000} into a 24-bit TX register, assert o_busy, go to SETUP.
REQ-020 i_start outside IDLE (including in DONE) SHALL be ignored; captured operands SHALL NOT change mid-frame.
REQ-021 SETUP: o_cs_n=0, o_sclk=0, o_mosi=TX bit 23 for DIV clocks, then TX.
REQ-022 The SCLK generator SHALL toggle o_sclk every DIV clocks; one SCLK period = 2*DIV clocks.
REQ-023 TX: 24 SCLK periods; o_mosi SHALL change only at SCLK falling edges (or SETUP entry) and be stable across each rising edge; bit order argA[7]..argA[0], argB[7..0], oper[3..0], 0000.
REQ-024 GAP: GAP_SCLK SCLK periods with o_mosi=0 and o_cs_n=0 (slave result-load cycle).
REQ-025 RX: RESP_BITS SCLK periods; i_miso SHALL be sampled on each SCLK falling edge into a shift register, MSB first.
REQ-026 Response mapping: first 8 bits = result[7:0], next 4 = flags[3:0], remaining RESP_BITS-12 discarded but still clocked.
REQ-027 After the last RX falling edge SHALL enter DONE: o_cs_n=1, o_sclk=0, o_mosi=0, o_result/o_flags loaded, o_valid=1 for exactly one clock, then IDLE with o_busy=0.
REQ-028 Latency start-acceptance-cycle to o_valid = 1 + DIV + (24+GAP_SCLK+RESP_BITS)*2*DIV clocks (215 at defaults).
REQ-029 Minimum spacing: a new i_start SHALL be accepted no earlier than the clock after o_valid.
REQ-030 o_result/o_flags SHALL hold their value until the next o_valid.
REQ-031 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-032 o_cs_n SHALL stay low continuously from SETUP to DONE; no SCLK edges while o_cs_n=1.

Reset
REQ-033 With i_rst_n=0 at a rising edge: state=IDLE, o_sclk=0, o_cs_n=1, o_mosi=0, o_result=0, o_flags=0, o_valid=0, o_busy=0, all counters and shift registers 0.
REQ-034 Reset mid-frame SHALL abort the frame at the next clock edge (o_cs_n=1 immediately), without an o_valid pulse or output update.
REQ-035 i_start coincident with active reset SHALL be ignored.

Verification
REQ-036 DIV=2; start argA=0x05, argB=0x03, oper=0x1; slave model returns 0x08, flags 0x0 -> MOSI stream 0x05,0x03,0x10; o_valid 215 clocks after start; o_result=0x08, o_flags=0x0.
REQ-037 Slave model returns 0xFF, flags 0xF, padding 0xFFFF -> o_result=0xFF, o_flags=0xF; padding ignored; exactly 53 SCLK rising edges per frame.
REQ-038 i_start pulsed every clock during a frame with differing operands -> one frame only, MOSI carries originally captured operands.
REQ-039 i_rst_n=0 at clock 100 of a frame -> o_cs_n=1 and o_sclk=0 next clock, no o_valid, o_result keeps 0; new start afterwards completes normally.
REQ-040 DIV=1, back-to-back starts (i_start held high) -> second frame's SETUP begins the clock after o_valid; o_cs_n high for at least one clock between frames.
REQ-041 Protocol checker throughout: o_mosi stable at every o_sclk rise; o_sclk low whenever o_cs_n=1; o_valid width exactly 1.

Source files
------------

// File: rtl/spi_exe_master.sv
// SPI master for an execution slave: ships {argA, argB, oper, 4'b0} MSB first,
// then clocks back a result/flags response and presents it with a one-cycle o_valid.
module spi_exe_master #(
  parameter int unsigned DIV       = 2,
  parameter int unsigned RESP_BITS = 28,
  parameter int unsigned GAP_SCLK  = 1
) (
  input  logic       i_clk_p,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_argA,
  input  logic [7:0] i_argB,
  input  logic [3:0] i_oper,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic       o_mosi,
  output logic [7:0] o_result,
  output logic [3:0] o_flags,
  output logic       o_valid,
  output logic       o_busy
);

  localparam int unsigned TX_BITS  = 24;
  localparam int unsigned DIV_W    = 8;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned MAX_A    = (RESP_BITS > TX_BITS) ? RESP_BITS : TX_BITS;
  localparam int unsigned MAX_BITS = (GAP_SCLK > MAX_A) ? GAP_SCLK : MAX_A;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_TX,
    S_GAP,
    S_RX,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TX_BITS-1:0]     tx_q, tx_d;
  logic [RESP_BITS-1:0]   rx_q, rx_d;
  logic                   sclk_q, sclk_d;
  logic                   cs_n_q, cs_n_d;
  logic                   mosi_q, mosi_d;
  logic [7:0]             result_q, result_d;
  logic [3:0]             flags_q, flags_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic                   tick;
  logic [IDX_W-1:0]       tx_idx;

  // tick marks the end of an SCLK half-period
  assign tick   = (div_cnt_q == DIV_W'(DIV - 1));
  // after n falling edges in TX the next bit to present is tx_q[22-n]
  assign tx_idx = IDX_W'(TX_BITS - 2) - IDX_W'(bit_cnt_q);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    result_d  = result_q;
    flags_d   = flags_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;

    if (state_q inside {S_SETUP, S_TX, S_GAP, S_RX}) begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          tx_d      = {i_argA, i_argB, i_oper, 4'b0000};
          rx_d      = '0;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          mosi_d    = i_argA[7];
          busy_d    = 1'b1;
          state_d   = S_SETUP;
        end
      end

      S_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = S_TX;
        end
      end

      S_TX: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          // MOSI only moves on the falling edge so it is stable at every rise
          if (sclk_q) begin
            if (bit_cnt_q == CNT_W'(TX_BITS - 1)) begin
              mosi_d    = 1'b0;
              bit_cnt_d = '0;
              state_d   = (GAP_SCLK != 0) ? S_GAP : S_RX;
            end else begin
              mosi_d    = tx_q[tx_idx];
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      S_GAP: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            if (bit_cnt_q == CNT_W'(GAP_SCLK - 1)) begin
              bit_cnt_d = '0;
              state_d   = S_RX;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      S_RX: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d    = 1'b0;
            rx_d      = {rx_q[RESP_BITS-2:0], i_miso};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (bit_cnt_q == CNT_W'(RESP_BITS)) begin
            // last low half-period elapsed: close the frame instead of rising again
            cs_n_d    = 1'b1;
            mosi_d    = 1'b0;
            result_d  = rx_q[RESP_BITS-1 -: 8];
            flags_d   = rx_q[RESP_BITS-9 -: 4];
            valid_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = S_DONE;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign o_sclk   = sclk_q;
  assign o_cs_n   = cs_n_q;
  assign o_mosi   = mosi_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;
  assign o_valid  = valid_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_spi_exe_master.sv
// Scoreboard bench: DIV=2 master against a serial slave model, plus a DIV=1
// master (MISO tied high) for back-to-back framing.
module tb_spi_exe_master;

  localparam int RESP_BITS = 28;
  localparam int RISES     = 53;   // 24 + 1 + 28 SCLK periods
  localparam int LAT2      = 215;  // 1 + 2 + 53*2*2
  localparam int LAT1      = 108;  // 1 + 1 + 53*2*1

  typedef struct {
    logic [7:0]  res;
    logic [3:0]  flg;
    logic [23:0] mosi;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, miso;
  logic [7:0] arg_a, arg_b;
  logic [3:0] oper;
  logic       o_sclk, o_cs_n, o_mosi, o_valid, o_busy;
  logic [7:0] o_result;
  logic [3:0] o_flags;

  logic       start1, miso1;
  logic       o_sclk1, o_cs_n1, o_mosi1, o_valid1, o_busy1;
  logic [7:0] o_result1;
  logic [3:0] o_flags1;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [27:0] resp_word = '0;
  logic [23:0] mosi_cap = '0;
  int          rise_n = 0;
  int          rx_idx;
  logic        sclk_prev = 1'b0, mosi_prev = 1'b0, valid_prev = 1'b0, valid1_prev = 1'b0;
  logic        mon_en = 1'b0;

  spi_exe_master #(.DIV(2), .RESP_BITS(RESP_BITS), .GAP_SCLK(1)) u_dut (
    .i_clk_p(clk), .i_rst_n(rst_n), .i_start(start),
    .i_argA(arg_a), .i_argB(arg_b), .i_oper(oper), .i_miso(miso),
    .o_sclk(o_sclk), .o_cs_n(o_cs_n), .o_mosi(o_mosi),
    .o_result(o_result), .o_flags(o_flags), .o_valid(o_valid), .o_busy(o_busy)
  );

  spi_exe_master #(.DIV(1), .RESP_BITS(RESP_BITS), .GAP_SCLK(1)) u_dut1 (
    .i_clk_p(clk), .i_rst_n(rst_n), .i_start(start1),
    .i_argA(8'h12), .i_argB(8'h34), .i_oper(4'h5), .i_miso(miso1),
    .o_sclk(o_sclk1), .o_cs_n(o_cs_n1), .o_mosi(o_mosi1),
    .o_result(o_result1), .o_flags(o_flags1), .o_valid(o_valid1), .o_busy(o_busy1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // slave model + scoreboard + protocol checks for the DIV=2 master
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", o_result, mon_e.res);
          chk("flags", o_flags, mon_e.flg);
          chk("mosi_word", mosi_cap, mon_e.mosi);
          chk("latency", cyc - mon_e.t0, LAT2);
          chk("sclk_rises", rise_n, RISES);
          chk("busy_at_valid", o_busy, 1);
        end
      end
      if (valid_prev) chk("valid_width", o_valid, 0);
      if (o_cs_n) begin
        chk("sclk_idle", o_sclk, 0);
        rise_n = 0;
      end else if (o_sclk && !sclk_prev) begin
        rise_n++;
        chk("mosi_stable", o_mosi, mosi_prev);
        if (rise_n <= 24) begin
          mosi_cap = {mosi_cap[22:0], o_mosi};
        end else if (rise_n > RISES - RESP_BITS && rise_n <= RISES) begin
          rx_idx = RISES - rise_n;
          miso = resp_word[rx_idx];
        end
      end
    end
    valid_prev = o_valid;
    sclk_prev  = o_sclk;
    mosi_prev  = o_mosi;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_cs_n1) chk("sclk_idle1", o_sclk1, 0);
      if (valid1_prev) chk("valid_width1", o_valid1, 0);
    end
    valid1_prev = o_valid1;
  end

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic [27:0] resp);
    exp_t e;
    resp_word = resp;
    arg_a = a;
    arg_b = b;
    oper  = op;
    start = 1'b1;
    e.res  = resp[27:20];
    e.flg  = resp[19:16];
    e.mosi = {a, b, op, 4'h0};
    e.t0   = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input bit which, input int budget, output int at);
    int n;
    n  = 0;
    at = -1;
    while (!(which ? o_valid1 : o_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (which ? o_valid1 : o_valid) at = cyc;
    else chk(which ? "valid1_timeout" : "valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          tv, t1, v1, v2, gap;
    logic [7:0]  last_res, ra, rb;
    logic [3:0]  last_flg, rop;
    logic [27:0] rresp;

    rst_n = 1'b0; start = 1'b0; miso = 1'b0; arg_a = '0; arg_b = '0; oper = '0;
    start1 = 1'b0; miso1 = 1'b1;
    repeat (2) @(negedge clk);
    // start while reset is active must be ignored
    start = 1'b1; start1 = 1'b1; arg_a = 8'hAA;
    repeat (2) @(negedge clk);
    chk("rst_cs_n", o_cs_n, 1);
    chk("rst_sclk", o_sclk, 0);
    chk("rst_mosi", o_mosi, 0);
    chk("rst_result", o_result, 0);
    chk("rst_flags", o_flags, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_cs_n1", o_cs_n1, 1);
    start = 1'b0; start1 = 1'b0; rst_n = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("idle_cs_n", o_cs_n, 1);

    // reset 100 clocks into a frame aborts it without o_valid
    run_frame(8'h11, 8'h22, 4'h3, 28'h0ABCDEF);
    chk("run_busy", o_busy, 1);
    chk("run_cs_n", o_cs_n, 0);
    repeat (98) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_cs_n", o_cs_n, 1);
    chk("abort_sclk", o_sclk, 0);
    chk("abort_valid", o_valid, 0);
    chk("abort_result", o_result, 0);
    chk("abort_busy", o_busy, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_stays_idle", o_cs_n, 1);

    // 5 + 3 with opcode 1 -> result 0x08, no flags
    run_frame(8'h05, 8'h03, 4'h1, {8'h08, 4'h0, 16'h0000});
    wait_valid(1'b0, 400, tv);
    @(negedge clk);
    chk("busy_after_valid", o_busy, 0);
    chk("valid_dropped", o_valid, 0);
    last_res = 8'h08;
    last_flg = 4'h0;

    // all-ones response: padding must not leak into result/flags
    chk("hold_result", o_result, last_res);
    chk("hold_flags", o_flags, last_flg);
    run_frame(8'hFF, 8'h00, 4'hF, 28'hFFFFFFF);
    wait_valid(1'b0, 400, tv);
    last_res = 8'hFF;
    last_flg = 4'hF;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      chk("hold_result_r", o_result, last_res);
      ra = 8'($urandom); rb = 8'($urandom); rop = 4'($urandom); rresp = 28'($urandom);
      run_frame(ra, rb, rop, rresp);
      wait_valid(1'b0, 400, tv);
      last_res = rresp[27:20];
      last_flg = rresp[19:16];
      repeat (2) @(negedge clk);
    end

    // i_start held with changing operands mid-frame: one frame, original operands
    run_frame(8'hC3, 8'h5A, 4'h9, 28'h5A5A5A5);
    for (int i = 0; i < 200; i++) begin
      start = 1'b1;
      arg_a = 8'(i);
      arg_b = ~8'(i);
      oper  = 4'(i);
      @(negedge clk);
    end
    start = 1'b0;
    wait_valid(1'b0, 100, tv);
    repeat (30) @(negedge clk);
    chk("single_frame_busy", o_busy, 0);
    chk("single_frame_cs_n", o_cs_n, 1);
    chk("single_frame_result", o_result, 8'h5A);
    chk("single_frame_flags", o_flags, 4'h5);

    // DIV=1, i_start held: next frame accepted the clock after o_valid
    start1 = 1'b1;
    t1 = cyc;
    wait_valid(1'b1, 300, v1);
    chk("b2b_latency", v1 - t1, LAT1);
    chk("b2b_result", o_result1, 8'hFF);
    chk("b2b_flags", o_flags1, 4'hF);
    @(negedge clk);
    gap = 0;
    while (o_cs_n1 && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    chk("b2b_cs_n_gap", (gap >= 1), 1);
    wait_valid(1'b1, 300, v2);
    chk("b2b_spacing", v2 - v1, LAT1 + 1);
    start1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
